// File: rtl/dense_layer_folded_pkg.sv
// ---------------------------------------------------------------------------
// dense_layer_folded_pkg
// Shared types and helpers for the time-folded dense layer.
//   state_t    : controller states (IDLE, LOAD, MAC, FIN, DONE)
//   groups()   : number of lane groups needed to cover all output neurons
//   sat_round(): fixed-point round-half-up, optional ReLU and saturation
// ---------------------------------------------------------------------------
package dense_layer_folded_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC,
      FIN,
      DONE
   } state_t;

   // Ceiling division: how many passes of the lane array cover every neuron.
   function automatic int groups(input int outNeur, input int lanes);
      return (outNeur + lanes - 1) / lanes;
   endfunction

   // Takes a sign-extended accumulator, drops fracW fractional bits with
   // round-half-up, optionally clamps negatives to zero, then saturates to
   // a signed dataW-bit range. The result is returned sign-extended to 64 bits.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                    input int dataW,
                                                    input int fracW,
                                                    input bit reluEn);
      logic signed [63:0] r;
      logic signed [63:0] maxV;
      logic signed [63:0] minV;
      r    = (acc + (64'sd1 <<< (fracW - 1))) >>> fracW;
      maxV = (64'sd1 <<< (dataW - 1)) - 64'sd1;
      minV = -(64'sd1 <<< (dataW - 1));
      if (reluEn && (r < 64'sd0)) begin
         r = 64'sd0;
      end
      if (r > maxV) begin
         r = maxV;
      end else if (r < minV) begin
         r = minV;
      end
      return r;
   endfunction

endpackage

// File: rtl/dense_layer_folded_if.sv
// ---------------------------------------------------------------------------
// dense_layer_folded_if
// Control, parameter-write and result bus of the folded dense layer.
//   start / in_vec                : inference request and its input vector
//   wr_en / wr_bias / wr_row /
//   wr_col / wr_data              : weight/bias RAM write port
//   out_vec / busy / done         : results and status
// master drives requests (the client), slave is the layer itself.
// ---------------------------------------------------------------------------
interface dense_layer_folded_if #(
   parameter int DATA_W   = 16,
   parameter int IN_NEUR  = 121,
   parameter int OUT_NEUR = 32
);
   localparam int ROW_W = (OUT_NEUR > 1) ? $clog2(OUT_NEUR) : 1;
   localparam int COL_W = (IN_NEUR > 1) ? $clog2(IN_NEUR) : 1;

   logic                               start;
   logic [IN_NEUR-1:0][DATA_W-1:0]     in_vec;
   logic                               wr_en;
   logic                               wr_bias;
   logic [ROW_W-1:0]                   wr_row;
   logic [COL_W-1:0]                   wr_col;
   logic [DATA_W-1:0]                  wr_data;
   logic [OUT_NEUR-1:0][DATA_W-1:0]    out_vec;
   logic                               busy;
   logic                               done;

   modport master (
      output start, in_vec, wr_en, wr_bias, wr_row, wr_col, wr_data,
      input  out_vec, busy, done
   );

   modport slave (
      input  start, in_vec, wr_en, wr_bias, wr_row, wr_col, wr_data,
      output out_vec, busy, done
   );

endinterface

// File: rtl/dense_layer_folded_mac_lane.sv
// ---------------------------------------------------------------------------
// dense_layer_folded_mac_lane
// One multiply-accumulate lane of the folded dense layer.
//   clk, rst_n : clock, async active-low reset (clears the accumulator)
//   load_i     : preload accumulator with bias aligned to the product scale
//   acc_en_i   : add data_i * weight_i to the accumulator
//   bias_i     : signed bias in data format
//   data_i     : signed input sample
//   weight_i   : signed weight
//   result_o   : rounded, optionally rectified, saturated accumulator value
// ---------------------------------------------------------------------------
module dense_layer_folded_mac_lane
   import dense_layer_folded_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 8,
   parameter int ACC_W   = 40,
   parameter int RELU_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_i,
   input  logic                     acc_en_i,
   input  logic signed [DATA_W-1:0] bias_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic signed [DATA_W-1:0] weight_i,
   output logic signed [DATA_W-1:0] result_o
);

   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [63:0]         rounded;

   // Full-precision signed product; both operands widened first so the
   // multiply happens at the product width.
   assign prod = (2*DATA_W)'(data_i) * (2*DATA_W)'(weight_i);

   // Next accumulator value: the bias is shifted up by FRAC_W so it sits at
   // the same binary point as a data*weight product (2*FRAC_W fraction bits).
   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = ACC_W'(bias_i) <<< FRAC_W;
      end else if (acc_en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Post-processing back to data format; the top samples this in FIN.
   assign rounded  = sat_round(64'(acc_q), DATA_W, FRAC_W, RELU_EN != 0);
   assign result_o = DATA_W'(rounded);

endmodule

// File: rtl/dense_layer_folded.sv
// ---------------------------------------------------------------------------
// dense_layer_folded
// Time-folded fully-connected layer: LANES MAC lanes sweep the OUT_NEUR
// neurons in groups, consuming one input sample per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : dense_layer_folded_if slave port
//                (start/in_vec request, wr_* parameter writes,
//                 out_vec/busy/done results)
// Weight and bias RAMs are written through the bus while idle and are not
// cleared by reset.
// ---------------------------------------------------------------------------
module dense_layer_folded
   import dense_layer_folded_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 8,
   parameter int IN_NEUR  = 121,
   parameter int OUT_NEUR = 32,
   parameter int LANES    = 8,
   parameter int ACC_W    = 40,
   parameter int RELU_EN  = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   dense_layer_folded_if.slave bus
);

   localparam int GROUPS = groups(OUT_NEUR, LANES);
   localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IDX_W  = (IN_NEUR > 1) ? $clog2(IN_NEUR) : 1;
   localparam int ROW_W  = (OUT_NEUR > 1) ? $clog2(OUT_NEUR) : 1;

   state_t                          state_q;
   logic                            busy_q;
   logic                            done_q;
   logic [GRP_W-1:0]                grp_q;
   logic [IDX_W-1:0]                idx_q;
   logic [IN_NEUR-1:0][DATA_W-1:0]  in_buf_q;
   logic [OUT_NEUR-1:0][DATA_W-1:0] out_vec_q;

   logic [DATA_W-1:0] weight_q [OUT_NEUR][IN_NEUR];
   logic [DATA_W-1:0] bias_q   [OUT_NEUR];

   logic              acceptStart;
   logic              acceptWr;
   logic              lastIdx;
   logic              lastGrp;
   logic              laneLoad;
   logic              laneAcc;
   logic [DATA_W-1:0] laneRes [LANES];
   logic [31:0]       laneRow [LANES];

   // A new inference is taken only from a truly idle controller; busy stays
   // high through the done cycle, which also blocks a start during done.
   assign acceptStart = bus.start && (state_q == IDLE) && !busy_q;
   assign acceptWr    = bus.wr_en && !busy_q;
   assign lastIdx     = (idx_q == IDX_W'(IN_NEUR - 1));
   assign lastGrp     = (grp_q == GRP_W'(GROUPS - 1));

   // Lanes preload bias before the first group and again while finishing
   // each non-final group, so the next group's MAC starts immediately.
   assign laneLoad = (state_q == LOAD) || ((state_q == FIN) && !lastGrp);
   assign laneAcc  = (state_q == MAC);

   // Parameter RAM write port; out-of-range addresses are dropped so no
   // write ever lands outside the arrays.
   always_ff @(posedge clk) begin
      if (acceptWr) begin
         if (bus.wr_bias) begin
            if (32'(bus.wr_row) < 32'(OUT_NEUR)) begin
               bias_q[bus.wr_row] <= bus.wr_data;
            end
         end else if ((32'(bus.wr_row) < 32'(OUT_NEUR)) &&
                      (32'(bus.wr_col) < 32'(IN_NEUR))) begin
            weight_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
         end
      end
   end

   // One lane per generate slice. Each lane maps to neuron grp*LANES+l;
   // tail lanes past OUT_NEUR see zero weight/bias instead of reading
   // beyond the RAMs. The bias row looks one group ahead during FIN because
   // that is when the next group's accumulators are reloaded.
   for (genvar l = 0; l < LANES; l++) begin : gLane
      logic [31:0]              wRow;
      logic [31:0]              bRow;
      logic signed [DATA_W-1:0] wSel;
      logic signed [DATA_W-1:0] bSel;

      assign wRow       = 32'(grp_q) * 32'(LANES) + 32'(l);
      assign bRow       = (32'(grp_q) + 32'(state_q == FIN)) * 32'(LANES) + 32'(l);
      assign laneRow[l] = wRow;

      // Guarded RAM read for this lane.
      always_comb begin
         wSel = '0;
         bSel = '0;
         if (wRow < 32'(OUT_NEUR)) begin
            wSel = weight_q[ROW_W'(wRow)][idx_q];
         end
         if (bRow < 32'(OUT_NEUR)) begin
            bSel = bias_q[ROW_W'(bRow)];
         end
      end

      dense_layer_folded_mac_lane #(
         .DATA_W  (DATA_W),
         .FRAC_W  (FRAC_W),
         .ACC_W   (ACC_W),
         .RELU_EN (RELU_EN)
      ) uLane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (laneLoad),
         .acc_en_i (laneAcc),
         .bias_i   (bSel),
         .data_i   (in_buf_q[idx_q]),
         .weight_i (wSel),
         .result_o (laneRes[l])
      );
   end

   // Controller: sequences LOAD -> (MAC x IN_NEUR -> FIN) x GROUPS -> DONE
   // and owns every registered output. The input vector is captured when
   // the start is accepted, so later in_vec changes cannot leak in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         grp_q     <= '0;
         idx_q     <= '0;
         in_buf_q  <= '0;
         out_vec_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (acceptStart) begin
                  busy_q   <= 1'b1;
                  in_buf_q <= bus.in_vec;
                  grp_q    <= '0;
                  idx_q    <= '0;
                  state_q  <= LOAD;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            LOAD: begin
               state_q <= MAC;
            end
            MAC: begin
               if (lastIdx) begin
                  state_q <= FIN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            FIN: begin
               for (int l = 0; l < LANES; l++) begin
                  if (laneRow[l] < 32'(OUT_NEUR)) begin
                     out_vec_q[ROW_W'(laneRow[l])] <= laneRes[l];
                  end
               end
               if (lastGrp) begin
                  state_q <= DONE;
               end else begin
                  grp_q   <= grp_q + 1'b1;
                  idx_q   <= '0;
                  state_q <= MAC;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_vec = out_vec_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_dense_layer_folded.sv
// ---------------------------------------------------------------------------
// tb_dense_layer_folded
// Drives two copies of the dense layer (ReLU on and off) with the same
// stimulus and compares their outputs with an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_dense_layer_folded;

   localparam int     DATA_W   = 16;
   localparam int     FRAC_W   = 8;
   localparam int     IN_NEUR  = 4;
   localparam int     OUT_NEUR = 5;
   localparam int     LANES    = 2;
   localparam int     ACC_W    = 40;
   localparam longint SCALE    = 256;
   localparam int     LATENCY  = 17;

   logic                           clk = 1'b0;
   logic                           rst_n;
   logic                           start;
   logic                           wrEn;
   logic                           wrBias;
   logic [2:0]                     wrRow;
   logic [1:0]                     wrCol;
   logic [DATA_W-1:0]              wrData;
   logic [IN_NEUR-1:0][DATA_W-1:0] inVec;

   int errors = 0;
   int checks = 0;

   int wM  [OUT_NEUR][IN_NEUR];
   int bM  [OUT_NEUR];
   int inM [IN_NEUR];

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   dense_layer_folded_if #(.DATA_W(DATA_W), .IN_NEUR(IN_NEUR), .OUT_NEUR(OUT_NEUR)) ifR ();
   dense_layer_folded_if #(.DATA_W(DATA_W), .IN_NEUR(IN_NEUR), .OUT_NEUR(OUT_NEUR)) ifL ();

   assign ifR.start   = start;
   assign ifR.in_vec  = inVec;
   assign ifR.wr_en   = wrEn;
   assign ifR.wr_bias = wrBias;
   assign ifR.wr_row  = wrRow;
   assign ifR.wr_col  = wrCol;
   assign ifR.wr_data = wrData;
   assign ifL.start   = start;
   assign ifL.in_vec  = inVec;
   assign ifL.wr_en   = wrEn;
   assign ifL.wr_bias = wrBias;
   assign ifL.wr_row  = wrRow;
   assign ifL.wr_col  = wrCol;
   assign ifL.wr_data = wrData;

   dense_layer_folded #(
      .DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_NEUR(IN_NEUR), .OUT_NEUR(OUT_NEUR),
      .LANES(LANES), .ACC_W(ACC_W), .RELU_EN(1)
   ) dutRelu (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifR)
   );

   dense_layer_folded #(
      .DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_NEUR(IN_NEUR), .OUT_NEUR(OUT_NEUR),
      .LANES(LANES), .ACC_W(ACC_W), .RELU_EN(0)
   ) dutLin (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifL)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference neuron: real-valued dot product plus bias, rounded half up,
   // then optional rectification and clamping to the 16-bit range.
   function automatic longint expectOut(input int n, input bit relu);
      longint acc;
      longint num;
      longint q;
      acc = longint'(bM[n]) * SCALE;
      for (int i = 0; i < IN_NEUR; i++) begin
         acc += longint'(inM[i]) * longint'(wM[n][i]);
      end
      num = acc + SCALE / 2;
      q   = num / SCALE;
      if (((num % SCALE) != 0) && (num < 0)) begin
         q = q - 1;
      end
      if (relu && (q < 0)) q = 0;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   // One parameter write through the RAM port, mirrored into the model.
   task automatic applyStimulus(input bit isBias, input int row, input int col, input int data);
      wrEn   = 1'b1;
      wrBias = isBias;
      wrRow  = 3'(row);
      wrCol  = 2'(col);
      wrData = 16'(data);
      tick();
      wrEn   = 1'b0;
      if (isBias) bM[row] = data;
      else        wM[row][col] = data;
   endtask

   task automatic setAllWeights(input int w);
      for (int n = 0; n < OUT_NEUR; n++)
         for (int i = 0; i < IN_NEUR; i++)
            applyStimulus(1'b0, n, i, w);
   endtask

   task automatic setAllBias(input int b);
      for (int n = 0; n < OUT_NEUR; n++) applyStimulus(1'b1, n, 0, b);
   endtask

   task automatic setAllInputs(input int v);
      for (int i = 0; i < IN_NEUR; i++) inM[i] = v;
   endtask

   task automatic driveInputs();
      for (int i = 0; i < IN_NEUR; i++) inVec[i] = 16'(inM[i]);
   endtask

   task automatic checkAll(input string tag);
      for (int n = 0; n < OUT_NEUR; n++) begin
         checkOutput($sformatf("%s.relu[%0d]", tag, n), $signed(ifR.out_vec[n]), expectOut(n, 1'b1));
         checkOutput($sformatf("%s.lin[%0d]", tag, n), $signed(ifL.out_vec[n]), expectOut(n, 1'b0));
      end
   endtask

   // Starts an inference, scrambles in_vec after acceptance, waits (bounded)
   // for done and checks latency, busy and the done pulse. With disturb set,
   // start and a weight write are pulsed mid-run and start is held over the
   // done cycle; none of them may take effect.
   task automatic runInference(input string tag, input bit disturb);
      int cycles;
      bit busyLost;
      cycles   = 0;
      busyLost = 1'b0;
      driveInputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      wrEn  = 1'b0;
      inVec = {$urandom, $urandom};
      if (!ifR.busy) busyLost = 1'b1;
      while (!ifR.done && (cycles < 200)) begin
         tick();
         cycles++;
         if (!ifR.busy) busyLost = 1'b1;
         if (disturb && (cycles == 3)) begin
            start  = 1'b1;
            wrEn   = 1'b1;
            wrBias = 1'b0;
            wrRow  = 3'd0;
            wrCol  = 2'd0;
            wrData = 16'd0;
         end else if (disturb && (cycles == 4)) begin
            start = 1'b0;
            wrEn  = 1'b0;
         end
      end
      checkOutput({tag, ".latency"}, cycles, LATENCY);
      checkOutput({tag, ".busyHeld"}, busyLost, 0);
      checkOutput({tag, ".doneLin"}, ifL.done, 1);
      if (disturb) start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, ".donePulse"}, ifR.done, 0);
      checkOutput({tag, ".busyEnd"}, ifR.busy, 0);
   endtask

   // Safety net in case a wait ever escapes its bound.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit sawDone;
      rst_n  = 1'b0;
      start  = 1'b0;
      wrEn   = 1'b0;
      wrBias = 1'b0;
      wrRow  = '0;
      wrCol  = '0;
      wrData = '0;
      inVec  = '0;
      tick();
      tick();

      $display("[TB] reset state");
      for (int n = 0; n < OUT_NEUR; n++) begin
         checkOutput($sformatf("reset.relu[%0d]", n), $signed(ifR.out_vec[n]), 0);
         checkOutput($sformatf("reset.lin[%0d]", n), $signed(ifL.out_vec[n]), 0);
      end
      checkOutput("reset.busy", ifR.busy, 0);
      checkOutput("reset.done", ifR.done, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] test 1: unit weights");
      setAllWeights(256);
      setAllBias(0);
      setAllInputs(256);
      runInference("t1", 1'b0);
      checkAll("t1");

      $display("[TB] test 2: negative neuron");
      for (int i = 0; i < IN_NEUR; i++) applyStimulus(1'b0, 2, i, -256);
      runInference("t2", 1'b0);
      checkAll("t2");

      $display("[TB] test 3: saturation");
      setAllWeights(32767);
      setAllInputs(32767);
      runInference("t3pos", 1'b0);
      checkAll("t3pos");
      setAllWeights(-32768);
      runInference("t3neg", 1'b0);
      checkAll("t3neg");

      $display("[TB] test 4: rounding");
      setAllWeights(0);
      setAllInputs(0);
      inM[0] = 1;
      for (int n = 0; n < OUT_NEUR; n++) applyStimulus(1'b0, n, 0, 128);
      runInference("t4half", 1'b0);
      checkAll("t4half");
      for (int n = 0; n < OUT_NEUR; n++) applyStimulus(1'b0, n, 0, 127);
      runInference("t4below", 1'b0);
      checkAll("t4below");
      for (int n = 0; n < OUT_NEUR; n++) applyStimulus(1'b0, n, 0, 128);
      applyStimulus(1'b1, 4, 0, 512);
      runInference("t4bias", 1'b0);
      checkAll("t4bias");

      $display("[TB] test 5: reset mid-run");
      setAllWeights(256);
      setAllBias(0);
      setAllInputs(256);
      driveInputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      for (int n = 0; n < OUT_NEUR; n++) begin
         checkOutput($sformatf("t5rst.relu[%0d]", n), $signed(ifR.out_vec[n]), 0);
      end
      checkOutput("t5rst.busy", ifR.busy, 0);
      sawDone = 1'b0;
      repeat (3) begin
         tick();
         if (ifR.done || ifL.done) sawDone = 1'b1;
      end
      rst_n = 1'b1;
      tick();
      if (ifR.done || ifL.done) sawDone = 1'b1;
      checkOutput("t5rst.noDone", sawDone, 0);
      runInference("t5", 1'b0);
      checkAll("t5");

      $display("[TB] test 6: requests while busy");
      runInference("t6", 1'b1);
      checkAll("t6");

      $display("[TB] random vectors");
      for (int it = 0; it < 3; it++) begin
         for (int n = 0; n < OUT_NEUR; n++) begin
            for (int i = 0; i < IN_NEUR; i++) begin
               if (it == 2) applyStimulus(1'b0, n, i, int'($urandom_range(65535)) - 32768);
               else         applyStimulus(1'b0, n, i, int'($urandom_range(1023)) - 512);
            end
            if (n < OUT_NEUR - 1) applyStimulus(1'b1, n, 0, int'($urandom_range(4095)) - 2048);
         end
         for (int i = 0; i < IN_NEUR; i++) begin
            if (it == 2) inM[i] = int'($urandom_range(65535)) - 32768;
            else         inM[i] = int'($urandom_range(1023)) - 512;
         end
         // Last bias is written in the same cycle the start is accepted.
         bM[OUT_NEUR-1] = int'($urandom_range(4095)) - 2048;
         wrEn   = 1'b1;
         wrBias = 1'b1;
         wrRow  = 3'(OUT_NEUR - 1);
         wrCol  = 2'd0;
         wrData = 16'(bM[OUT_NEUR-1]);
         runInference($sformatf("rnd%0d", it), 1'b0);
         checkAll($sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
